time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 138 +++++++++++++
 tb/tb_time_keeper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Time-of-day keeper: prescaled one-second tick, HH:MM:SS with up/down counting,
// manual adjust, validated preset load and 12/24-hour BCD display.
module time_keeper #(
    parameter int TICK_DIV = 100,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             up_down,
    input  logic             adj_min,
    input  logic             adj_hr,
    input  logic             mode_12h,
    input  logic             load,
    input  logic [4:0]       load_h,
    input  logic [5:0]       load_m,
    input  logic [5:0]       load_s,
    output logic [1:0]       hr_tens,
    output logic [3:0]       hr_units,
    output logic [2:0]       min_tens,
    output logic [3:0]       min_units,
    output logic [2:0]       sec_tens,
    output logic [3:0]       sec_units,
    output logic             pm,
    output logic             tick,
    output logic             day_wrap,
    output logic             load_err
);

    logic [CNT_W-1:0] presc;
    logic [5:0]       cur_sec;
    logic [5:0]       cur_min;
    logic [4:0]       cur_hr;
    logic             presc_end;
    logic             tick_int;
    logic             adj_any;
    logic             load_ok;
    logic [4:0]       disp_hr;

    assign presc_end = (presc == CNT_W'(TICK_DIV - 1));
    assign tick_int  = run_en && presc_end;
    assign adj_any   = adj_min || adj_hr;
    assign load_ok   = (load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59);
    assign tick      = tick_int && !rst && !load && !adj_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            cur_sec  <= '0;
            cur_min  <= '0;
            cur_hr   <= '0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    cur_hr  <= load_h;
                    cur_min <= load_m;
                    cur_sec <= load_s;
                    presc   <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                if (run_en)
                    presc <= presc_end ? '0 : presc + CNT_W'(1);
                // Adjust steps share the prescaler but swallow this cycle's tick.
                if (adj_any) begin
                    if (adj_min) begin
                        if (up_down) cur_min <= (cur_min == 6'd59) ? 6'd0 : cur_min + 6'd1;
                        else         cur_min <= (cur_min == 6'd0) ? 6'd59 : cur_min - 6'd1;
                    end
                    if (adj_hr) begin
                        if (up_down) cur_hr <= (cur_hr == 5'd23) ? 5'd0 : cur_hr + 5'd1;
                        else         cur_hr <= (cur_hr == 5'd0) ? 5'd23 : cur_hr - 5'd1;
                    end
                end else if (tick_int) begin
                    if (up_down) begin
                        if (cur_sec == 6'd59) begin
                            cur_sec <= 6'd0;
                            if (cur_min == 6'd59) begin
                                cur_min <= 6'd0;
                                if (cur_hr == 5'd23) begin
                                    cur_hr   <= 5'd0;
                                    day_wrap <= 1'b1;
                                end else begin
                                    cur_hr <= cur_hr + 5'd1;
                                end
                            end else begin
                                cur_min <= cur_min + 6'd1;
                            end
                        end else begin
                            cur_sec <= cur_sec + 6'd1;
                        end
                    end else begin
                        if (cur_sec == 6'd0) begin
                            cur_sec <= 6'd59;
                            if (cur_min == 6'd0) begin
                                cur_min <= 6'd59;
                                if (cur_hr == 5'd0) begin
                                    cur_hr   <= 5'd23;
                                    day_wrap <= 1'b1;
                                end else begin
                                    cur_hr <= cur_hr - 5'd1;
                                end
                            end else begin
                                cur_min <= cur_min - 6'd1;
                            end
                        end else begin
                            cur_sec <= cur_sec - 6'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        disp_hr = cur_hr;
        if (mode_12h) begin
            if (cur_hr == 5'd0)
                disp_hr = 5'd12;
            else if (cur_hr > 5'd12)
                disp_hr = cur_hr - 5'd12;
        end
    end

    assign pm        = (cur_hr >= 5'd12);
    assign hr_tens   = 2'(disp_hr / 5'd10);
    assign hr_units  = 4'(disp_hr % 5'd10);
    assign min_tens  = 3'(cur_min / 6'd10);
    assign min_units = 4'(cur_min % 6'd10);
    assign sec_tens  = 3'(cur_sec / 6'd10);
    assign sec_units = 4'(cur_sec % 6'd10);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper (TICK_DIV=4): directed scenarios plus random traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst, run_en, up_down, adj_min, adj_hr, mode_12h, load;
    logic [4:0] load_h;
    logic [5:0] load_m, load_s;
    logic [1:0] hr_tens;
    logic [3:0] hr_units, min_units, sec_units;
    logic [2:0] min_tens, sec_tens;
    logic       pm, tick, day_wrap, load_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds since midnight, prescaler count.
    int  m_t = 0;
    int  m_p = 0;
    bit  m_dw = 0;
    bit  m_le = 0;

    time_keeper #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .up_down(up_down),
        .adj_min(adj_min), .adj_hr(adj_hr), .mode_12h(mode_12h), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hr_tens(hr_tens), .hr_units(hr_units), .min_tens(min_tens),
        .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
        .pm(pm), .tick(tick), .day_wrap(day_wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int h, dh, exp_tick;
        h  = m_t / 3600;
        dh = mode_12h ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
        exp_tick = (!rst && !load && !adj_min && !adj_hr && run_en && m_p == 3) ? 1 : 0;
        chk("hr_tens",   32'(hr_tens),   dh / 10);
        chk("hr_units",  32'(hr_units),  dh % 10);
        chk("min_tens",  32'(min_tens),  ((m_t / 60) % 60) / 10);
        chk("min_units", 32'(min_units), ((m_t / 60) % 60) % 10);
        chk("sec_tens",  32'(sec_tens),  (m_t % 60) / 10);
        chk("sec_units", 32'(sec_units), (m_t % 60) % 10);
        chk("pm",        32'(pm),        (h >= 12) ? 1 : 0);
        chk("tick",      32'(tick),      exp_tick);
        chk("day_wrap",  32'(day_wrap),  32'(m_dw));
        chk("load_err",  32'(load_err),  32'(m_le));
    endtask

    task automatic model_step();
        int h, m, s, d;
        bit tk;
        if (rst) begin
            m_t = 0; m_p = 0; m_dw = 0; m_le = 0;
            return;
        end
        m_dw = 0; m_le = 0;
        if (load) begin
            if (load_h <= 23 && load_m <= 59 && load_s <= 59) begin
                m_t = int'(load_h) * 3600 + int'(load_m) * 60 + int'(load_s);
                m_p = 0;
            end else begin
                m_le = 1;
            end
            return;
        end
        tk = run_en && (m_p == 3);
        if (run_en) m_p = (m_p + 1) % 4;
        d = up_down ? 1 : -1;
        if (adj_min || adj_hr) begin
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
            if (adj_min) m = (m + d + 60) % 60;
            if (adj_hr)  h = (h + d + 24) % 24;
            m_t = h * 3600 + m * 60 + s;
        end else if (tk) begin
            if (up_down) begin
                m_t = (m_t + 1) % 86400;
                m_dw = (m_t == 0);
            end else begin
                m_dw = (m_t == 0);
                m_t = (m_t + 86399) % 86400;
            end
        end
    endtask

    // Inputs are set by the caller at the falling edge; settle, check, step.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; load = 0; adj_min = 0; adj_hr = 0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1; load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
        cycle();
        load = 0;
    endtask

    task automatic chk_time24(input string tag, input int h, input int m, input int s);
        chk(tag, 32'(hr_tens * 10 + hr_units) * 10000 + 32'(min_tens * 10 + min_units) * 100
                 + 32'(sec_tens * 10 + sec_units), h * 10000 + m * 100 + s);
    endtask

    initial begin
        rst = 1; run_en = 0; up_down = 1; adj_min = 0; adj_hr = 0; mode_12h = 0;
        load = 0; load_h = '0; load_m = '0; load_s = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset state in both display modes.
        cycle();
        idle_inputs();
        #1;
        chk_time24("reset_24h", 0, 0, 0);
        mode_12h = 1;
        #1;
        chk("reset_12h_hr", 32'(hr_tens * 10 + hr_units), 12);
        chk("reset_12h_pm", 32'(pm), 0);
        mode_12h = 0;

        // Free run up for 240 cycles.
        run_en = 1; up_down = 1;
        for (int i = 0; i < 240; i++) cycle();
        chk_time24("run_240", 0, 1, 0);

        // Day wrap upward and downward.
        do_load(23, 59, 59);
        for (int i = 0; i < 6; i++) cycle();
        chk_time24("wrap_up", 0, 0, 0);
        do_load(0, 0, 0);
        up_down = 0;
        for (int i = 0; i < 6; i++) cycle();
        chk_time24("wrap_down", 23, 59, 59);

        // Rejected loads leave time unchanged.
        run_en = 0; up_down = 1;
        do_load(12, 34, 56);
        do_load(24, 0, 0);  cycle();
        do_load(0, 60, 0);  cycle();
        do_load(0, 0, 60);  cycle();
        chk_time24("rejected_loads", 12, 34, 56);

        // Adjust steps without carry.
        do_load(10, 59, 30);
        adj_min = 1; up_down = 1; cycle(); adj_min = 0;
        chk_time24("adj_min_wrap", 10, 0, 30);
        do_load(0, 30, 15);
        adj_hr = 1; up_down = 0; cycle(); adj_hr = 0;
        chk_time24("adj_hr_wrap", 23, 30, 15);
        adj_min = 1; adj_hr = 1; up_down = 1; cycle(); idle_inputs();
        chk_time24("adj_both", 0, 31, 15);

        // 12-hour display at hr 0 / 12 / 13.
        mode_12h = 1;
        do_load(0, 0, 0);  cycle();
        do_load(12, 0, 0); cycle();
        do_load(13, 0, 0); cycle();
        chk("12h_13_hr", 32'(hr_tens * 10 + hr_units), 1);
        chk("12h_13_pm", 32'(pm), 1);
        mode_12h = 0;

        // Adjust landing on the tick cycle suppresses the advance.
        do_load(5, 5, 5);
        run_en = 1; up_down = 1;
        for (int i = 0; i < 3; i++) cycle();
        adj_min = 1;
        #1;
        chk("adj_tick_gated", 32'(tick), 0);
        cycle();
        adj_min = 0;
        chk_time24("adj_no_advance", 5, 6, 5);

        // Reset during a bad load leaves no error pulse.
        load = 1; load_h = 5'd30; rst = 1; cycle(); idle_inputs();
        chk("rst_over_load", 32'(load_err), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            run_en   = ($urandom_range(0, 9) != 0);
            up_down  = 1'($urandom);
            mode_12h = 1'($urandom);
            adj_min  = ($urandom_range(0, 15) == 0);
            adj_hr   = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            load_h   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 23));
            load_m   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 59));
            load_s   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 59));
            if ($urandom_range(0, 99) == 0) begin
                load = 1; load_h = 5'd23; load_m = 6'd59; load_s = 6'($urandom_range(57, 59));
            end
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
